ar_window_filter: RTL and testbench

Registered, multi-window successor to the single-bank AXI read-address forward filter. It sits between an AR-channel broadcast point and one downstream slave port. Each beat's address field is decoded against NUM_WIN mask/bank windows, and matching beats pass through a 2-entry registered skid FIFO tagged with the winning window. Non-matching beats are either refused (parallel-filter mode) or sunk and counted (terminal mode).

---
 rtl/ar_window_filter.sv | 70 +++++++
 tb/tb_ar_window_filter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ar_window_filter.sv
// ar_window_filter: multi-window AR address filter feeding a 2-entry registered skid FIFO, with miss drop counting
module ar_window_filter #(
  parameter int DATA_W = 77,
  parameter int ADDR_LSB = 33,
  parameter int ADDR_W = 36,
  parameter int NUM_WIN = 2,
  parameter logic [NUM_WIN*ADDR_W-1:0] WIN_MASK = '0,
  parameter logic [NUM_WIN*ADDR_W-1:0] WIN_BANK = '0,
  parameter int MISS_MODE = 0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [DATA_W-1:0] DATAi,
  input  logic              VALIDi,
  output logic              READYi,
  output logic [DATA_W-1:0] DATAo,
  output logic [NUM_WIN-1:0] WINo,
  output logic              VALIDo,
  input  logic              READYo,
  input  logic              MISS_CLR,
  output logic [15:0]       MISS_CNT,
  output logic              MISSo
);
  logic [ADDR_W-1:0] addr;
  logic [NUM_WIN-1:0] win;
  logic [DATA_W-1:0] skid_d;
  logic [NUM_WIN-1:0] skid_w;
  logic skid_v, hit, push, pop, drop, load_head;
  assign addr = DATAi[ADDR_LSB +: ADDR_W];
  // descending scan so the lowest matching window is the one left standing
  always_comb begin
    win = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--)
      win = ((addr & WIN_MASK[i*ADDR_W +: ADDR_W]) == WIN_BANK[i*ADDR_W +: ADDR_W]) ? NUM_WIN'(1) << i : win;
  end
  assign hit = |win;
  assign READYi = ARESETn & ((MISS_MODE != 0) ? (~skid_v | ~hit) : (hit & ~skid_v));
  assign push = VALIDi & READYi & hit;
  assign pop = VALIDo & READYo;
  assign drop = VALIDi & READYi & ~hit & (MISS_MODE != 0);
  assign load_head = pop | ~VALIDo;
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      DATAo <= '0;
      WINo <= '0;
      VALIDo <= 1'b0;
      skid_d <= '0;
      skid_w <= '0;
      skid_v <= 1'b0;
      MISS_CNT <= '0;
      MISSo <= 1'b0;
    end else begin
      MISSo <= drop;
      MISS_CNT <= MISS_CLR ? '0 : MISS_CNT + 16'(drop & ~&MISS_CNT);
      if (load_head && skid_v) begin
        DATAo <= skid_d;
        WINo <= skid_w;
      end else if (load_head && push) begin
        DATAo <= DATAi;
        WINo <= win;
      end
      if (load_head) VALIDo <= skid_v | push;
      if (push && (skid_v || !load_head)) begin
        skid_d <= DATAi;
        skid_w <= win;
      end
      skid_v <= load_head ? (skid_v & push) : (skid_v | push);
    end
  end
endmodule

// File: tb/tb_ar_window_filter.sv
// tb_ar_window_filter: three filter instances (refuse, drop-count, overlapping windows) on a shared AR bus
module tb_ar_window_filter;
  typedef struct packed {logic [76:0] d; logic [1:0] w;} beat_t;
  logic clk = 1'b0;
  logic rstn, valid_i, ready_o, miss_clr;
  logic [76:0] data_i;
  logic [2:0] ready_i, valid_o, miss_o;
  logic [76:0] data_o [3];
  logic [1:0] win_o [3];
  logic [15:0] miss_cnt [3];
  bit armed = 1'b0;
  int n_asrt = 0, n_fail = 0;
  logic [76:0] d, a_d, b_d, c_d;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [79:0] obs, input logic [79:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[u%0d] observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [76:0] beat(input logic [35:0] a);
    return {8'($urandom), a, 33'($urandom)};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam logic [3:0] BANK1 = (g == 2) ? 4'h1 : 4'h2;
    ar_window_filter #(
      .DATA_W(77), .ADDR_LSB(33), .ADDR_W(36), .NUM_WIN(2),
      .WIN_MASK({2{36'hF00000000}}),
      .WIN_BANK({BANK1, 32'h0, 36'h100000000}),
      .MISS_MODE(g == 1 ? 1 : 0)
    ) u (
      .ACLK(clk), .ARESETn(rstn), .DATAi(data_i), .VALIDi(valid_i), .READYi(ready_i[g]),
      .DATAo(data_o[g]), .WINo(win_o[g]), .VALIDo(valid_o[g]), .READYo(ready_o),
      .MISS_CLR(miss_clr), .MISS_CNT(miss_cnt[g]), .MISSo(miss_o[g])
    );
    beat_t q[$];
    logic [15:0] exp_cnt = '0;
    logic exp_miss = 1'b0;
    always @(negedge clk) if (armed) begin
      logic [3:0] nib;
      logic [1:0] w;
      logic er, drop;
      nib = data_i[68:65];
      w = (nib == 4'h1) ? 2'b01 : (nib == BANK1) ? 2'b10 : 2'b00;
      er = rstn && (g == 1 ? (q.size() < 2 || w == 2'b00) : (w != 2'b00 && q.size() < 2));
      chk("ready_i", g, ready_i[g], er);
      chk("valid_o", g, valid_o[g], q.size() != 0);
      chk("miss_o", g, miss_o[g], exp_miss);
      chk("miss_cnt", g, miss_cnt[g], exp_cnt);
      if (q.size() != 0) begin
        chk("sb_data", g, data_o[g], q[0].d);
        chk("sb_win", g, win_o[g], q[0].w);
      end
      if (!rstn) begin
        q.delete();
        exp_cnt = '0;
        exp_miss = 1'b0;
      end else begin
        drop = valid_i && er && w == 2'b00;
        if (q.size() != 0 && ready_o) void'(q.pop_front());
        if (valid_i && er && w != 2'b00) q.push_back({data_i, w});
        exp_miss = drop;
        exp_cnt = miss_clr ? 16'h0 : (drop && exp_cnt != 16'hFFFF) ? exp_cnt + 16'h1 : exp_cnt;
      end
    end
  end

  initial begin
    rstn = 1'b0; valid_i = 1'b1; ready_o = 1'b1; miss_clr = 1'b0;
    data_i = beat(36'h100000000);
    @(posedge clk);
    armed = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, ready_i[i], 0);
      chk("rst_valid", i, valid_o[i], 0);
      chk("rst_data", i, data_o[i], 0);
      chk("rst_cnt", i, miss_cnt[i], 0);
    end
    step; rstn = 1'b1; valid_i = 1'b0; data_i = beat(36'h300000000);
    @(negedge clk);
    chk("rel_ready_refuse", 0, ready_i[0], 0);
    chk("rel_ready_sink", 1, ready_i[1], 1);
    // single hit on window 1
    step; d = beat(36'h200000040); data_i = d; valid_i = 1'b1;
    step; valid_i = 1'b0;
    @(negedge clk);
    chk("hit_valid", 0, valid_o[0], 1);
    chk("hit_data", 0, data_o[0], d);
    chk("hit_win", 0, win_o[0], 2'b10);
    // backpressure: two fill the FIFO, the third is refused until a pop
    step; ready_o = 1'b0; a_d = beat(36'h100000010); data_i = a_d; valid_i = 1'b1;
    step; b_d = beat(36'h200000020); data_i = b_d;
    step; c_d = beat(36'h100000030); data_i = c_d;
    @(negedge clk);
    chk("bp_ready_c", 0, ready_i[0], 0);
    chk("bp_head_hold", 0, data_o[0], a_d);
    step; ready_o = 1'b1;
    @(negedge clk);
    chk("bp_out_a", 0, data_o[0], a_d);
    step;
    @(negedge clk);
    chk("bp_out_b", 0, data_o[0], b_d);
    chk("bp_ready_reopen", 0, ready_i[0], 1);
    step; valid_i = 1'b0;
    @(negedge clk);
    chk("bp_out_c", 0, data_o[0], c_d);
    chk("bp_valid_c", 0, valid_o[0], 1);
    step;
    @(negedge clk);
    chk("bp_empty", 0, valid_o[0], 0);
    // overlapping windows: lowest index wins
    step; d = beat(36'h100000000); data_i = d; valid_i = 1'b1;
    step; valid_i = 1'b0;
    @(negedge clk);
    chk("prio_win", 2, win_o[2], 2'b01);
    chk("prio_data", 2, data_o[2], d);
    // miss in refuse mode
    step; data_i = beat(36'h300000000); valid_i = 1'b1;
    @(negedge clk);
    chk("miss0_ready", 0, ready_i[0], 0);
    step; valid_i = 1'b0;
    @(negedge clk);
    chk("miss0_valid", 0, valid_o[0], 0);
    chk("miss0_cnt", 0, miss_cnt[0], 0);
    chk("miss1_pulse", 1, miss_o[1], 1);
    chk("miss1_cnt", 1, miss_cnt[1], 1);
    // five back-to-back drops
    step; miss_clr = 1'b1;
    step; miss_clr = 1'b0; valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      if (i == 4) valid_i = 1'b0;
      @(negedge clk);
      chk("miss5_pulse", 1, miss_o[1], 1);
      chk("miss5_valid", 1, valid_o[1], 0);
    end
    chk("miss5_cnt", 1, miss_cnt[1], 5);
    step;
    @(negedge clk);
    chk("miss5_pulse_end", 1, miss_o[1], 0);
    // clear coincident with a drop
    step; miss_clr = 1'b1; valid_i = 1'b1;
    step; miss_clr = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("clr_cnt", 1, miss_cnt[1], 0);
    chk("clr_pulse", 1, miss_o[1], 1);
    // saturation
    step; valid_i = 1'b1;
    repeat (65534) step;
    valid_i = 1'b0;
    @(negedge clk);
    chk("sat_preload", 1, miss_cnt[1], 16'hFFFE);
    step; valid_i = 1'b1;
    repeat (3) step;
    valid_i = 1'b0;
    @(negedge clk);
    chk("sat_cnt", 1, miss_cnt[1], 16'hFFFF);
    // reset with a full FIFO
    step; ready_o = 1'b0; data_i = beat(36'h200000000); valid_i = 1'b1;
    step; data_i = beat(36'h100000000);
    step; valid_i = 1'b0; rstn = 1'b0;
    step; rstn = 1'b1;
    @(negedge clk);
    chk("midrst_valid0", 0, valid_o[0], 0);
    chk("midrst_valid1", 1, valid_o[1], 0);
    chk("midrst_cnt", 1, miss_cnt[1], 0);
    // sustained stream
    step; ready_o = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_i = beat(i % 2 ? 36'h200000100 : 36'h100000100);
      valid_i = 1'b1;
      @(negedge clk);
      if (i > 0) chk("stream_valid", 0, valid_o[0], 1);
      step;
    end
    valid_i = 1'b0;
    // random traffic, scoreboard only
    for (int i = 0; i < 400; i++) begin
      step;
      valid_i = 1'($urandom_range(0, 1));
      ready_o = $urandom_range(0, 3) != 0;
      miss_clr = $urandom_range(0, 15) == 0;
      data_i = beat({4'($urandom_range(1, 3)), 32'($urandom)});
    end
    step; valid_i = 1'b0; ready_o = 1'b1; miss_clr = 1'b0;
    repeat (4) step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
